// File: rtl/program_memory_loader.sv
// Program memory loader: turns a big-endian byte stream (16-bit word count header
// followed by data bytes) into 32-bit word writes. Optional trailing checksum: LOADER_CHECKSUM_EN.
module program_memory_loader #(
  parameter int MEMORY_DEPTH = 256,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            ByteData,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CHK    = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif
  localparam logic [16:0] MAX_WORDS = 17'(MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic [15:0]           word_count_q, word_count_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  logic        accept_s;
  logic        load_start_s;
  logic        last_byte_s;
  logic        last_word_s;
  logic [15:0] hdr_count_s;

  assign accept_s     = ByteValid & ByteReady;
  assign load_start_s = Start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
  assign last_byte_s  = (byte_cnt_q == 2'd3);
  assign last_word_s  = (word_idx_q == (word_count_q - 16'd1));
  assign hdr_count_s  = {word_count_q[15:8], ByteData};

  assign WriteEnable  = we_q;
  assign WriteAddress = waddr_q;
  assign WriteData    = wdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) state_d = S_HDR_HI;
        else       state_d = state_q;
      end
      S_HDR_HI: begin
        if (accept_s) state_d = S_HDR_LO;
        else          state_d = state_q;
      end
      S_HDR_LO: begin
        if (!accept_s)                              state_d = state_q;
        else if (hdr_count_s == 16'd0)              state_d = S_FINISH;
        else if ({1'b0, hdr_count_s} > MAX_WORDS)   state_d = S_ERROR;
        else                                        state_d = S_DATA;
      end
      S_DATA: begin
        if (accept_s && last_byte_s && last_word_s) state_d = S_FINISH;
        else                                        state_d = state_q;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (!accept_s)              state_d = state_q;
        else if (ByteData == xor_q) state_d = S_DONE;
        else                        state_d = S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    ByteReady = 1'b0;
    CpuHold   = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    case (state_q)
      S_HDR_HI, S_HDR_LO, S_DATA: begin
        ByteReady = 1'b1;
        CpuHold   = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        ByteReady = 1'b1;
        CpuHold   = 1'b1;
      end
`endif
      S_DONE:  Done = 1'b1;
      S_ERROR: begin
        Error   = 1'b1;
        CpuHold = 1'b1;
      end
      default: ByteReady = 1'b0;
    endcase
  end

  // Header capture, word assembly and write-port staging
  always_comb begin
    word_count_d = word_count_q;
    word_idx_d   = word_idx_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d        = xor_q;
    if (accept_s) xor_d = xor_q ^ ByteData;
    else          xor_d = xor_q;
`endif
    if (load_start_s) begin
      word_count_d = 16'd0;
      word_idx_d   = 16'd0;
      byte_cnt_d   = 2'd0;
      asm_d        = 24'd0;
`ifdef LOADER_CHECKSUM_EN
      xor_d        = 8'd0;
`endif
    end else if (accept_s) begin
      case (state_q)
        S_HDR_HI: word_count_d[15:8] = ByteData;
        S_HDR_LO: word_count_d[7:0]  = ByteData;
        S_DATA: begin
          asm_d      = {asm_q[15:0], ByteData};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte_s) begin
            // Word is complete: stage it for the write strobe on the next cycle.
            we_d       = 1'b1;
            wdata_d    = DATA_WIDTH'({asm_q, ByteData});
            waddr_d    = BASE_ADDRESS + DATA_WIDTH'({word_idx_q, 2'b00});
            word_idx_d = word_idx_q + 16'd1;
          end else begin
            we_d       = 1'b0;
          end
        end
        default: we_d = 1'b0;
      endcase
    end else begin
      we_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      word_count_q <= 16'd0;
      word_idx_q   <= 16'd0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 24'd0;
      we_q         <= 1'b0;
      waddr_q      <= {DATA_WIDTH{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= 8'd0;
`endif
    end else begin
      word_count_q <= word_count_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: directed vector table, hand-written
// corner sequences and randomized loads against a behavioural model.
module tb_program_memory_loader;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, Start, ByteValid;
  logic [7:0]  ByteData;
  logic        ByteReady, WriteEnable, CpuHold, Done, Error;
  logic [31:0] WriteAddress, WriteData;

  always #5 clk = ~clk;

  program_memory_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .BASE_ADDRESS(BASE)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ByteData(ByteData), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
    .WriteData(WriteData), .CpuHold(CpuHold), .Done(Done), .Error(Error)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]  stim_q[$];
  logic [31:0] got_addr_q[$], got_data_q[$];
  logic        got_done_q[$];
  logic [31:0] exp_addr_q[$], exp_data_q[$];
  logic        exp_done, exp_error;

  typedef struct {
    int          n;
    logic [95:0] bytes;
    int          gap;
    int          nwr;
    logic        done;
    logic        err;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;
  vec_t vt[5];

  // Write monitor
  always @(negedge clk) begin
    if (WriteEnable) begin
      got_addr_q.push_back(WriteAddress);
      got_data_q.push_back(WriteData);
      got_done_q.push_back(Done);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    logic ok;
    ok = 1'b0;
    ByteValid = 1'b1;
    ByteData  = b;
    for (int n = 0; n < 50 && !ok; n++) begin
      r = ByteReady;
      step();
      if (r) ok = 1'b1;
    end
    ByteValid = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_stream(input int gapmode);
    int g;
    foreach (stim_q[k]) begin
      g = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (g) step();
      send_byte(stim_q[k]);
    end
  endtask

  task automatic do_start();
    got_addr_q.delete();
    got_data_q.delete();
    got_done_q.delete();
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("start_done_clr", {31'd0, Done}, 32'd0);
    check("start_err_clr", {31'd0, Error}, 32'd0);
    check("start_hold", {31'd0, CpuHold}, 32'd1);
    check("start_ready", {31'd0, ByteReady}, 32'd1);
  endtask

  task automatic run_load(input int gapmode);
    do_start();
    send_stream(gapmode);
    step();
    step();
  endtask

  task automatic append_chk();
    logic [7:0] x;
    x = 8'd0;
    foreach (stim_q[k]) x ^= stim_q[k];
    stim_q.push_back(x);
  endtask

  // Reference: header count, big-endian words at BASE+4*i, optional XOR trailer
  function automatic void model();
    int count;
    int k;
    logic [7:0] x;
    exp_addr_q.delete();
    exp_data_q.delete();
    count = int'(stim_q[0]) * 256 + int'(stim_q[1]);
    if (count > DEPTH) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
      return;
    end
    for (int i = 0; i < count; i++) begin
      k = 2 + 4 * i;
      exp_data_q.push_back(32'(stim_q[k]) * 32'h0100_0000 + 32'(stim_q[k+1]) * 32'h0001_0000 +
                           32'(stim_q[k+2]) * 32'h0000_0100 + 32'(stim_q[k+3]));
      exp_addr_q.push_back(BASE + 32'(4 * i));
    end
    exp_done  = 1'b1;
    exp_error = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    x = 8'd0;
    for (int j = 0; j < stim_q.size() - 1; j++) x ^= stim_q[j];
    if (stim_q[stim_q.size()-1] != x) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
    end
`endif
  endfunction

  task automatic compare_model(input int it);
    model();
    check($sformatf("rnd%0d_nwr", it), got_data_q.size(), exp_data_q.size());
    for (int i = 0; i < exp_data_q.size() && i < got_data_q.size(); i++) begin
      check($sformatf("rnd%0d_addr%0d", it, i), got_addr_q[i], exp_addr_q[i]);
      check($sformatf("rnd%0d_data%0d", it, i), got_data_q[i], exp_data_q[i]);
    end
    check($sformatf("rnd%0d_done", it), {31'd0, Done}, {31'd0, exp_done});
    check($sformatf("rnd%0d_error", it), {31'd0, Error}, {31'd0, exp_error});
    check($sformatf("rnd%0d_hold", it), {31'd0, CpuHold}, {31'd0, exp_error});
  endtask

  initial begin
    int count;
    reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteData = 8'd0;
    step();
    step();
    reset = 1'b0;
    check("rst_ready", {31'd0, ByteReady}, 32'd0);
    check("rst_we", {31'd0, WriteEnable}, 32'd0);
    check("rst_addr", WriteAddress, 32'd0);
    check("rst_data", WriteData, 32'd0);
    check("rst_hold", {31'd0, CpuHold}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_error", {31'd0, Error}, 32'd0);

    vt[0] = '{10, 96'h0002_2008_0005_2009_0007_0000, 0, 2, 1'b1, 1'b0, 32'h2008_0005, 32'h2009_0007};
    vt[1] = '{10, 96'h0002_2008_0005_2009_0007_0000, 1, 2, 1'b1, 1'b0, 32'h2008_0005, 32'h2009_0007};
    vt[2] = '{2,  96'h0101_0000_0000_0000_0000_0000, 0, 0, 1'b0, 1'b1, 32'h0, 32'h0};
    vt[3] = '{2,  96'h0000_0000_0000_0000_0000_0000, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0};
    vt[4] = '{6,  96'h0001_dead_beef_0000_0000_0000, 2, 1, 1'b1, 1'b0, 32'hdead_beef, 32'hdead_beef};

    for (int v = 0; v < 5; v++) begin
      stim_q.delete();
      for (int k = 0; k < vt[v].n; k++) stim_q.push_back(vt[v].bytes[95-8*k -: 8]);
`ifdef LOADER_CHECKSUM_EN
      if (!vt[v].err) append_chk();
`endif
      run_load(vt[v].gap);
      check($sformatf("vec%0d_nwr", v), got_data_q.size(), vt[v].nwr);
      if (vt[v].nwr > 0 && got_data_q.size() > 0) begin
        check($sformatf("vec%0d_first_addr", v), got_addr_q[0], BASE);
        check($sformatf("vec%0d_first_data", v), got_data_q[0], vt[v].first);
        check($sformatf("vec%0d_last_data", v), got_data_q[got_data_q.size()-1], vt[v].last);
        check($sformatf("vec%0d_hold_addr", v), WriteAddress, BASE + 32'(4 * (vt[v].nwr - 1)));
        check($sformatf("vec%0d_hold_data", v), WriteData, vt[v].last);
`ifndef LOADER_CHECKSUM_EN
        check($sformatf("vec%0d_done_at_wr", v), {31'd0, got_done_q[got_done_q.size()-1]}, 32'd1);
`endif
      end
      check($sformatf("vec%0d_done", v), {31'd0, Done}, {31'd0, vt[v].done});
      check($sformatf("vec%0d_error", v), {31'd0, Error}, {31'd0, vt[v].err});
      check($sformatf("vec%0d_hold", v), {31'd0, CpuHold}, {31'd0, vt[v].err});
      check($sformatf("vec%0d_ready", v), {31'd0, ByteReady}, 32'd0);
    end

    // Reset in the middle of a 3-word load, after 6 data bytes
    stim_q = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_start();
    send_stream(0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_ready", {31'd0, ByteReady}, 32'd0);
    check("mid_rst_we", {31'd0, WriteEnable}, 32'd0);
    check("mid_rst_addr", WriteAddress, 32'd0);
    check("mid_rst_data", WriteData, 32'd0);
    check("mid_rst_hold", {31'd0, CpuHold}, 32'd0);
    check("mid_rst_status", {30'd0, Done, Error}, 32'd0);
    ByteValid = 1'b1;
    ByteData  = 8'h77;
    repeat (10) step();
    ByteValid = 1'b0;
    check("mid_rst_nwr", got_data_q.size(), 32'd1);
    if (got_data_q.size() > 0) check("mid_rst_wdata", got_data_q[0], 32'h1122_3344);

`ifdef LOADER_CHECKSUM_EN
    stim_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    run_load(0);
    check("chk_good_done", {31'd0, Done}, 32'd1);
    check("chk_good_nwr", got_data_q.size(), 32'd1);
    stim_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_load(0);
    check("chk_bad_error", {31'd0, Error}, 32'd1);
    check("chk_bad_hold", {31'd0, CpuHold}, 32'd1);
    check("chk_bad_nwr", got_data_q.size(), 32'd1);
`endif

    for (int it = 0; it < 25; it++) begin
      stim_q.delete();
      case ($urandom_range(0, 9))
        0:       count = 0;
        1:       count = 257 + int'($urandom_range(0, 2000));
        default: count = int'($urandom_range(1, 5));
      endcase
      if (it == 0) count = DEPTH;
      stim_q.push_back(8'(count >> 8));
      stim_q.push_back(8'(count));
      if (count <= DEPTH) begin
        for (int i = 0; i < 4 * count; i++) stim_q.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
        append_chk();
        if ($urandom_range(0, 3) == 0) stim_q[stim_q.size()-1] ^= 8'h5a;
`endif
      end
      run_load(int'($urandom_range(0, 2)));
      compare_model(it);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
- Write-side companion to the instruction ROM.
- Receives a byte stream over a valid/ready handshake from a serial receiver or testbench, assembles 32-bit big-endian instruction words, and issues one word write per instruction into the program memory array.
- Holds the CPU while a load is in progress, then releases it.

Parameters:
MEMORY_DEPTH, 256, number of instruction words in program memory; upper bound on accepted word count
DATA_WIDTH, 32, instruction and address width
BASE_ADDRESS, 32'h0000_0000, byte address of word 0; must be word-aligned

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle pulse that begins a load
ByteData  input  8  incoming byte
ByteValid  input  1  ByteData is valid this cycle
ByteReady  output  1  loader accepts the byte this cycle; transfer occurs when ByteValid and ByteReady are both 1
WriteEnable  output  1  one-cycle write strobe to program memory
WriteAddress  output  DATA_WIDTH  byte address of the word being written, word-aligned; the memory drops bits [1:0]
WriteData  output  DATA_WIDTH  instruction word being written
CpuHold  output  1  holds the processor PC/fetch while loading
Done  output  1  load completed successfully; level signal
Error  output  1  load aborted; level signal

Behaviour:
- Reset state: IDLE. All outputs are 0 (ByteReady, WriteEnable, WriteAddress, WriteData, CpuHold, Done, Error). Internal word counter, byte counter and assembly register are cleared.
- Reset mid-operation: the load is abandoned with no further writes. Words already written stay in memory.
- States: IDLE, HDR_HI, HDR_LO, DATA, CHK (only with the optional feature), DONE, ERROR.
- IDLE, DONE, ERROR + Start=1: go to HDR_HI. Done and Error clear on the next cycle; CpuHold=1.
- Start while in HDR_HI, HDR_LO, DATA or CHK: ignored.
- ByteReady=1 in HDR_HI, HDR_LO, DATA and CHK; 0 in all other states.
- HDR_HI: accepted byte -> WordCount[15:8]; go to HDR_LO.
- HDR_LO: accepted byte -> WordCount[7:0]. Then:
  - WordCount == 0 -> DONE (or CHK if the feature is enabled).
  - WordCount > MEMORY_DEPTH -> ERROR.
  - Otherwise -> DATA.
- DATA byte assembly:
  - Accepted bytes fill the word MSB first: byte 0 -> [31:24], byte 3 -> [7:0].
  - The byte counter wraps 3 -> 0.
- DATA write timing: the cycle after the 4th byte of word i is accepted:
  - WriteEnable=1 for exactly one cycle.
  - WriteData = assembled word.
  - WriteAddress = BASE_ADDRESS + 4*i.
- Back-to-back bytes: ByteReady stays 1 during the write cycle, so byte 0 of word i+1 can be accepted then without stalling.
- WriteAddress/WriteData hold their last values when WriteEnable=0.
- Leaving DATA: on accepting the final byte of word WordCount-1, go to DONE (or CHK). The final write still occurs on the following cycle; Done rises in that same cycle.
- DONE: Done=1, CpuHold=0, ByteReady=0.
- ERROR: Error=1, CpuHold stays 1 so the CPU does not run a partial image. Only reset or Start leaves ERROR.
- ByteValid=0 stalls assembly indefinitely; there is no timeout.
- Word index is 16 bits; address arithmetic is DATA_WIDTH bits, modulo 2^DATA_WIDTH.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all accepted header and data bytes is kept.
  - After the last data byte (or after HDR_LO if WordCount==0) the FSM enters CHK and accepts one more byte.
  - Byte equals the running XOR -> DONE; otherwise -> ERROR.
  - Writes already issued are not undone.
- Undefined: no CHK state and no XOR register; the load ends after the last data word.

Test Plan:
1. Reset, Start, stream 00 02 20 08 00 05 20 09 00 07 with ByteValid held high -> writes {0x0, 0x20080005} then {0x4, 0x20090007}, each WriteEnable exactly one cycle; Done=1, CpuHold=0 in the cycle of the second write.
2. Same stream with ByteValid toggling 1/0 every cycle -> identical writes and data, only later.
3. Header 01 01 (257 words, MEMORY_DEPTH=256) -> ERROR, Error=1, CpuHold=1, no writes. A following Start clears Error and re-enters HDR_HI.
4. Header 00 00 -> DONE two cycles after Start with no writes. With LOADER_CHECKSUM_EN, the trailing byte 00 is also required.
5. Assert reset after 6 data bytes of a 3-word load -> exactly one write issued; all outputs 0 on the next cycle; no further WriteEnable.
6. LOADER_CHECKSUM_EN, stream 00 01 12 34 56 78 + checksum 0x09 -> Done=1. Same stream with checksum 0x08 -> Error=1, after the single write has occurred.
